chip8_mem_arbiter: RTL and testbench
====================================

Name: chip8_mem_arbiter

Overview:
- Parametrised single-port memory arbiter between N requesters (index 0 = host bus, 1 = cpu, 2 = display by default) and one port of a synchronous RAM (chip_ram or display_ram).
- Fixed priority with starvation promotion, lock for multi-beat bursts (e.g. sprite draws), and per-requester read-data return routed through a latency pipeline.
- One instance per RAM port replaces the ad-hoc write/cpu/display muxing at the top level.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is highest priority.
- AW, 12, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (1..4).
- MAX_WAIT, 15, consecutive denied cycles before a requester is promoted; 0 disables promotion.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester access request
- lock  in  NUM_REQ  requester i keeps ownership while lock[i]&&req[i]
- we  in  NUM_REQ  1 = write, 0 = read
- addr  in  NUM_REQ*AW  flattened; requester i at [i*AW +: AW]
- wdata  in  NUM_REQ*DW  flattened write data
- gnt  out  NUM_REQ  one-hot grant; transfer occurs when req[i]&&gnt[i]
- rvalid  out  NUM_REQ  one-cycle strobe; rdata valid for requester i
- rdata  out  DW  shared read data, qualified by rvalid
- ram_a  out  AW  RAM address
- ram_d  out  DW  RAM write data
- ram_w  out  1  RAM write enable
- ram_q  in  DW  RAM read data, valid RD_LAT cycles after address

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: gnt=0, rvalid=0, ram_w=0, ram_a=0, ram_d=0, state=IDLE, all wait counters 0, read pipeline cleared.
- Grant is combinational from registered state and current req: at most one bit set, and gnt[i] only when req[i]=1.
- States:
  - IDLE: grant the winner. The winner is the lowest-index requester whose wait counter == MAX_WAIT (when MAX_WAIT>0); otherwise the lowest-index asserted req.
  - Going to LOCKED: if the winner also has lock=1, register owner=winner and move to LOCKED.
  - LOCKED: gnt[owner]=req[owner]; every other requester is denied.
  - Leaving LOCKED: go to IDLE when lock[owner]=0 or req[owner]=0. In that same cycle the normal IDLE winner selection applies, so there is no bubble.
- RAM drive: ram_a/ram_d/ram_w are combinational from the granted requester. ram_w = we[g] on a granted cycle, 0 otherwise. ram_a holds its previous value when nothing is granted.
- Read return:
  - A granted read pushes {valid=1, id=g} into an RD_LAT-deep shift register.
  - At the tail, rvalid[id]=1 and rdata=ram_q.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
- Wait counters:
  - wait[i] increments (saturating at MAX_WAIT) each cycle that req[i]=1 and gnt[i]=0.
  - It clears when gnt[i]=1 or req[i]=0.
  - Counter width is $clog2(MAX_WAIT+1), minimum 1.
- Simultaneous events:
  - Several requesters saturated: lowest index wins.
  - A saturated requester cannot break an active lock. It wins at the first IDLE evaluation.
- Write-then-read of the same address on consecutive cycles: the read returns the new data (the RAM is read-after-write ordered across cycles; no bypass).
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset), lock ownership is dropped, and counters clear.
- Requesters must hold addr/wdata/we stable while req=1 and gnt=0.

Decomposition:
- Package chip8_mem_pkg: arbiter state enum (ARB_IDLE, ARB_LOCKED), REQ_HOST=0/REQ_CPU=1/REQ_DISP=2 index constants, default AW/DW localparams for chip_ram (12/8) and display_ram (8/8).
- Sub-module rd_return_pipe (RD_LAT-deep valid+id shift register, parametrised by depth and id width).

Test Plan:
- Reset, then req=3'b111, all reads, no lock -> gnt=001 every cycle; with MAX_WAIT=15, gnt=010 on cycle 16 after the first denial.
- Requester 1 with lock=1 reads addr 0x200..0x203 over 4 cycles while req[0]=1 -> gnt=010 for 4 cycles, then gnt=001 the cycle lock drops; rvalid[1] pulses 4 times with the RAM contents at 0x200..0x203.
- Requester 0 writes 0xAB to 0x800, next cycle requester 2 reads 0x800 (RD_LAT=2) -> rvalid[2] two cycles later with rdata=0xAB.
- Interleaved reads: req0 at cycle t, req2 at t+1 (RD_LAT=1) -> rvalid=001 at t+1 and rvalid=100 at t+2, each with the correct data.
- Reset asserted one cycle after a granted read with RD_LAT=3 -> rvalid stays 0, gnt=0 and ram_w=0 during and after reset until a new req arrives.

Source files
------------

// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared definitions for the CHIP-8 memory arbiters: arbiter state encoding,
// requester index map and default geometry of the two RAMs.
package chip8_mem_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Requester index map; lower index means higher fixed priority.
    localparam int REQ_HOST = 0;
    localparam int REQ_CPU  = 1;
    localparam int REQ_DISP = 2;

    // Default address/data widths of the two RAMs behind an arbiter.
    localparam int CHIP_RAM_AW = 12;
    localparam int CHIP_RAM_DW = 8;
    localparam int DISP_RAM_AW = 8;
    localparam int DISP_RAM_DW = 8;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int width_for(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/chip8_mem_arbiter_rd_return_pipe.sv
// Read-return tracker: carries {valid, requester id} alongside the RAM read
// latency so the returning data can be steered back to its issuer.
module rd_return_pipe #(
    parameter int DEPTH = 1,
    parameter int IDW   = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_push,
    input  logic [IDW-1:0] i_id,
    output logic           o_valid,
    output logic [IDW-1:0] o_id
);

    logic [DEPTH-1:0] r_vld;
    logic [IDW-1:0]   r_id [DEPTH];

    // Valid bits shift toward the tail; cleared on reset so in-flight reads vanish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_push;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Requester ids follow the valid bits; only meaningful where valid is set.
    always_ff @(posedge clk) begin
        r_id[0] <= i_id;
        for (int i = 1; i < DEPTH; i++) begin
            r_id[i] <= r_id[i-1];
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port RAM arbiter: fixed priority with starvation promotion, burst
// locking, and per-requester routing of read data after the RAM latency.
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    lock,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ*DW-1:0] wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic [AW-1:0]         ram_a,
    output logic [DW-1:0]         ram_d,
    output logic                  ram_w,
    input  logic [DW-1:0]         ram_q
);

    localparam int IDW = width_for(NUM_REQ - 1);
    localparam int WW  = width_for(MAX_WAIT);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    arb_state_t        r_state;
    logic [IDW-1:0]    r_owner;
    logic [WW-1:0]     r_wait [NUM_REQ];
    logic [AW-1:0]     r_ram_a;
    logic [DW-1:0]     r_ram_d;

    logic              w_win_vld;
    logic [IDW-1:0]    w_win_idx;
    logic              w_prom_vld;
    logic [IDW-1:0]    w_prom_idx;
    logic              w_hold;
    logic              w_gnt_vld;
    logic [IDW-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_data;
    logic              w_rd_vld;
    logic [IDW-1:0]    w_rd_id;

    // IDLE winner: a saturated (starved) requester beats plain priority; lowest index wins ties.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_prom_vld = 1'b0;
        w_prom_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_vld = 1'b1;
                w_win_idx = IDW'(i);
            end
            if (MAX_WAIT > 0 && req[i] && r_wait[i] == WMAX) begin
                w_prom_vld = 1'b1;
                w_prom_idx = IDW'(i);
            end
        end
        if (w_prom_vld) begin
            w_win_idx = w_prom_idx;
        end
    end

    // An active lock keeps its owner; once it lapses the IDLE winner takes the same cycle.
    assign w_hold    = (r_state == ARB_LOCKED) && req[r_owner] && lock[r_owner];
    assign w_gnt_vld = !reset && (w_hold || w_win_vld);
    assign w_gnt_idx = w_hold ? r_owner : w_win_idx;

    // One-hot grant vector from the selected index.
    always_comb begin
        w_gnt = '0;
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign gnt        = w_gnt;
    assign w_sel_addr = addr[w_gnt_idx*AW +: AW];
    assign w_sel_data = wdata[w_gnt_idx*DW +: DW];

    // RAM port follows the granted requester; address/data hold when idle.
    assign ram_a = w_gnt_vld ? w_sel_addr : r_ram_a;
    assign ram_d = w_gnt_vld ? w_sel_data : r_ram_d;
    assign ram_w = w_gnt_vld && we[w_gnt_idx];

    // Remember the last driven address/data so the RAM port is stable between grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_a <= '0;
            r_ram_d <= '0;
        end else if (w_gnt_vld) begin
            r_ram_a <= w_sel_addr;
            r_ram_d <= w_sel_data;
        end
    end

    // Lock FSM: enter LOCKED when the granted winner asks for a burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
        end else if (w_hold) begin
            r_state <= ARB_LOCKED;
        end else if (w_win_vld && lock[w_win_idx]) begin
            r_state <= ARB_LOCKED;
            r_owner <= w_win_idx;
        end else begin
            r_state <= ARB_IDLE;
        end
    end

    // Per-requester starvation counters, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || !req[i] || w_gnt[i]) begin
                r_wait[i] <= '0;
            end else if (r_wait[i] != WMAX) begin
                r_wait[i] <= r_wait[i] + 1'b1;
            end
        end
    end

    rd_return_pipe #(
        .DEPTH (RD_LAT),
        .IDW   (IDW)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_gnt_vld && !we[w_gnt_idx]),
        .i_id    (w_gnt_idx),
        .o_valid (w_rd_vld),
        .o_id    (w_rd_id)
    );

    // Route the returning read strobe to the requester that issued it.
    always_comb begin
        rvalid = '0;
        if (w_rd_vld && !reset) begin
            rvalid[w_rd_id] = 1'b1;
        end
    end

    assign rdata = ram_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench: three arbiters (RD_LAT 1, 2, 3) share one stimulus stream,
// each with its own RAM model.
module tb_chip8_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  we;
    logic [11:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    logic [35:0] addr;
    logic [23:0] wdata;

    int n_tests = 0;
    int n_fail  = 0;

    assign addr  = {a2, a1, a0};
    assign wdata = {d2, d1, d0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = k + 1;
        logic [2:0]  gnt;
        logic [2:0]  rvalid;
        logic [7:0]  rdata;
        logic [11:0] ram_a;
        logic [7:0]  ram_d;
        logic        ram_w;
        logic [7:0]  ram_q;
        logic [7:0]  mem   [4096];
        logic [7:0]  qpipe [L];

        chip8_mem_arbiter #(
            .NUM_REQ  (3),
            .AW       (12),
            .DW       (8),
            .RD_LAT   (L),
            .MAX_WAIT (15)
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .req    (req),
            .lock   (lock),
            .we     (we),
            .addr   (addr),
            .wdata  (wdata),
            .gnt    (gnt),
            .rvalid (rvalid),
            .rdata  (rdata),
            .ram_a  (ram_a),
            .ram_d  (ram_d),
            .ram_w  (ram_w),
            .ram_q  (ram_q)
        );

        // Synchronous RAM with L cycles of read latency.
        always @(posedge clk) begin
            if (ram_w) mem[ram_a] <= ram_d;
            qpipe[0] <= mem[ram_a];
            for (int j = 1; j < L; j++) qpipe[j] <= qpipe[j-1];
        end
        assign ram_q = qpipe[L-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = '0; lock = '0; we = '0;
        a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0; d2 = '0;
        tick();
        tick();

        // Reset state
        #2;
        chk("rst_gnt",    32'(g_dut[0].gnt),    32'h0);
        chk("rst_rvalid", 32'(g_dut[2].rvalid), 32'h0);
        chk("rst_ram_w",  32'(g_dut[0].ram_w),  32'h0);
        chk("rst_ram_a",  32'(g_dut[0].ram_a),  32'h0);
        chk("rst_ram_d",  32'(g_dut[0].ram_d),  32'h0);
        tick();
        reset = 1'b0;
        #2;
        chk("idle_gnt", 32'(g_dut[0].gnt), 32'h0);
        tick();

        // Host preloads 0x200..0x203 with 0x11,0x22,0x33,0x44
        for (int k = 0; k < 4; k++) begin
            req = 3'b001; we = 3'b001;
            a0 = 12'(12'h200 + k);
            d0 = 8'((k + 1) * 8'h11);
            #2;
            chk("wr_gnt",   32'(g_dut[0].gnt),   32'h1);
            chk("wr_ram_w", 32'(g_dut[0].ram_w), 32'h1);
            chk("wr_ram_a", 32'(g_dut[0].ram_a), 32'h200 + k);
            chk("wr_ram_d", 32'(g_dut[0].ram_d), (k + 1) * 32'h11);
            tick();
        end
        req = '0; we = '0;
        #2;
        chk("hold_gnt",   32'(g_dut[0].gnt),   32'h0);
        chk("hold_ram_a", 32'(g_dut[0].ram_a), 32'h203);
        chk("hold_ram_w", 32'(g_dut[0].ram_w), 32'h0);
        tick();

        // Starvation promotion with all three requesting reads
        req = 3'b111; a0 = 12'h200; a1 = 12'h201; a2 = 12'h202;
        for (int c = 1; c <= 15; c++) begin
            #2;
            chk("starve_host", 32'(g_dut[0].gnt), 32'h1);
            tick();
        end
        #2;
        chk("promote_cpu", 32'(g_dut[0].gnt), 32'h2);
        tick();
        #2;
        chk("promote_disp", 32'(g_dut[0].gnt), 32'h4);
        tick();
        #2;
        chk("back_to_host", 32'(g_dut[0].gnt), 32'h1);
        tick();
        req = '0;
        repeat (4) tick();

        // Locked 4-beat burst by cpu while host also requests
        for (int k = 0; k < 6; k++) begin
            a0 = 12'h200;
            if (k < 4) begin
                req = (k == 0) ? 3'b010 : 3'b011;
                lock = 3'b010;
                a1 = 12'(12'h200 + k);
            end else if (k == 4) begin
                req = 3'b011; lock = 3'b000;
            end else begin
                req = 3'b000; lock = 3'b000;
            end
            #2;
            chk("lock_gnt", 32'(g_dut[0].gnt), (k < 4) ? 32'h2 : ((k == 4) ? 32'h1 : 32'h0));
            if (k >= 1 && k <= 4) begin
                chk("lock_rvalid_l1", 32'(g_dut[0].rvalid), 32'h2);
                chk("lock_rdata_l1",  32'(g_dut[0].rdata),  k * 32'h11);
            end
            if (k == 5) begin
                chk("lock_host_rvalid_l1", 32'(g_dut[0].rvalid), 32'h1);
                chk("lock_host_rdata_l1",  32'(g_dut[0].rdata),  32'h11);
            end
            if (k >= 2) begin
                chk("lock_rvalid_l2", 32'(g_dut[1].rvalid), 32'h2);
                chk("lock_rdata_l2",  32'(g_dut[1].rdata),  (k - 1) * 32'h11);
            end
            tick();
        end
        repeat (3) tick();

        // Host writes 0xAB to 0x800, display reads it back next cycle
        req = 3'b001; we = 3'b001; a0 = 12'h800; d0 = 8'hAB;
        #2;
        chk("raw_wr_gnt",   32'(g_dut[1].gnt),   32'h1);
        chk("raw_wr_ram_w", 32'(g_dut[1].ram_w), 32'h1);
        chk("raw_wr_ram_a", 32'(g_dut[1].ram_a), 32'h800);
        chk("raw_wr_ram_d", 32'(g_dut[1].ram_d), 32'hAB);
        tick();
        req = 3'b100; we = 3'b000; a2 = 12'h800;
        #2;
        chk("raw_rd_gnt",   32'(g_dut[1].gnt),   32'h4);
        chk("raw_rd_ram_w", 32'(g_dut[1].ram_w), 32'h0);
        chk("raw_rd_ram_a", 32'(g_dut[1].ram_a), 32'h800);
        tick();
        req = '0;
        #2;
        chk("raw_early_l2",  32'(g_dut[1].rvalid), 32'h0);
        chk("raw_rvalid_l1", 32'(g_dut[0].rvalid), 32'h4);
        chk("raw_rdata_l1",  32'(g_dut[0].rdata),  32'hAB);
        tick();
        #2;
        chk("raw_rvalid_l2", 32'(g_dut[1].rvalid), 32'h4);
        chk("raw_rdata_l2",  32'(g_dut[1].rdata),  32'hAB);
        tick();
        tick();

        // Interleaved reads: host then display on consecutive cycles
        req = 3'b001; a0 = 12'h201;
        #2;
        chk("il_gnt0", 32'(g_dut[0].gnt), 32'h1);
        tick();
        req = 3'b100; a2 = 12'h203;
        #2;
        chk("il_rvalid0_l1", 32'(g_dut[0].rvalid), 32'h1);
        chk("il_rdata0_l1",  32'(g_dut[0].rdata),  32'h22);
        tick();
        req = '0;
        #2;
        chk("il_rvalid2_l1", 32'(g_dut[0].rvalid), 32'h4);
        chk("il_rdata2_l1",  32'(g_dut[0].rdata),  32'h44);
        chk("il_rvalid0_l2", 32'(g_dut[1].rvalid), 32'h1);
        chk("il_rdata0_l2",  32'(g_dut[1].rdata),  32'h22);
        tick();
        #2;
        chk("il_rvalid2_l2", 32'(g_dut[1].rvalid), 32'h4);
        chk("il_rdata2_l2",  32'(g_dut[1].rdata),  32'h44);
        chk("il_quiet_l1",   32'(g_dut[0].rvalid), 32'h0);
        tick();
        repeat (2) tick();

        // Reset one cycle after a granted, locked read (RD_LAT=3 instance)
        req = 3'b010; lock = 3'b010; a1 = 12'h202;
        #2;
        chk("mid_gnt", 32'(g_dut[2].gnt), 32'h2);
        tick();
        reset = 1'b1; req = '0; lock = '0;
        #2;
        chk("mid_rst_gnt",    32'(g_dut[2].gnt),    32'h0);
        chk("mid_rst_rvalid", 32'(g_dut[2].rvalid), 32'h0);
        chk("mid_rst_ram_w",  32'(g_dut[2].ram_w),  32'h0);
        tick();
        reset = 1'b0; req = 3'b011; lock = 3'b010; a0 = 12'h200; a1 = 12'h201;
        #2;
        chk("mid_lock_dropped", 32'(g_dut[2].gnt),    32'h1);
        chk("mid_post_rvalid1", 32'(g_dut[2].rvalid), 32'h0);
        tick();
        req = '0; lock = '0;
        #2;
        chk("mid_post_rvalid2", 32'(g_dut[2].rvalid), 32'h0);
        chk("mid_post_gnt",     32'(g_dut[2].gnt),    32'h0);
        chk("mid_post_ram_w",   32'(g_dut[2].ram_w),  32'h0);
        tick();
        #2;
        chk("mid_post_rvalid3", 32'(g_dut[2].rvalid), 32'h0);
        tick();
        #2;
        chk("mid_new_rvalid", 32'(g_dut[2].rvalid), 32'h1);
        chk("mid_new_rdata",  32'(g_dut[2].rdata),  32'h11);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
